// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responder.
package mips_mem_responder_pkg;

    typedef enum logic [1:0] {
        M_Idle = 2'd0,
        M_Wait = 2'd1,
        M_Resp = 2'd2
    } mem_state_t;

    localparam int MEM_WORD_BYTES = 4;

    // Fault codes: only "non-zero" reaches the pins today; the distinction
    // is kept so a richer error response can be added without rework.
    localparam logic [3:0] FAULT_NONE     = 4'd0;
    localparam logic [3:0] FAULT_MISALIGN = 4'd1;
    localparam logic [3:0] FAULT_RANGE    = 4'd2;

    // Classify a byte address against the array size in bytes.
    function automatic logic [3:0] mem_fault_code(input logic [31:0] addr,
                                                  input logic [32:0] limit);
        logic [3:0] code;
        code = FAULT_NONE;
        if (addr[1:0] != 2'b00) begin
            code = FAULT_MISALIGN;
        end else if ({1'b0, addr} >= limit) begin
            code = FAULT_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mips_mem_responder_array.sv
// Word storage shared by fetch and data accesses. Writes are synchronous;
// the read port is combinational so the responder samples it at commit.
module mips_mem_array
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Store path: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// Single-outstanding memory responder: accept, wait, commit, respond.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; rsp_valid is a one-cycle strobe with no
// backpressure, and rsp_rdata/rsp_err are meaningful only while it is high.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) * 33'(MEM_WORD_BYTES);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        in_idle;
    logic        eff_write;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [3:0]  fault_code;
    logic        commit;
    logic        arr_we;
    logic [31:0] arr_rdata;

    // In Idle the commit (zero wait states) must see the live request,
    // otherwise the latched copy.
    always_comb begin
        in_idle    = (state_q == M_Idle);
        eff_write  = in_idle ? req_write : write_q;
        eff_addr   = in_idle ? req_addr  : addr_q;
        eff_wdata  = in_idle ? req_wdata : wdata_q;
        fault_code = mem_fault_code(eff_addr, LIMIT);
    end

    // Next-state, wait counter, request latch and commit of the response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            M_Idle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = M_Resp;
                        commit  = 1'b1;
                    end else begin
                        state_d = M_Wait;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            M_Wait: begin
                if (cnt_q == 4'd0) begin
                    state_d = M_Resp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            M_Resp: begin
                state_d = M_Idle;
            end
            default: begin
                state_d = M_Idle;
                cnt_d   = 4'd0;
            end
        endcase
        if (commit) begin
            if (fault_code != FAULT_NONE) begin
                rdata_d = 32'd0;
                err_d   = 1'b1;
            end else if (eff_write) begin
                rdata_d = eff_wdata;
                err_d   = 1'b0;
            end else begin
                rdata_d = arr_rdata;
                err_d   = 1'b0;
            end
        end
    end

    assign arr_we = commit && (fault_code == FAULT_NONE) && eff_write;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= M_Idle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    mips_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .idx  (eff_addr[IDX_W+1:2]),
        .wdata(eff_wdata),
        .rdata(arr_rdata)
    );

    // Handshake outputs come from the state register only (ready is also
    // held low while reset is asserted).
    assign req_ready = rst && (state_q == M_Idle);
    assign rsp_valid = (state_q == M_Resp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: one instance with two wait states, one with
// zero wait states, each with its own expected-response queue and monitor.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0;
    logic        req_valid2, req_write2, req_valid0, req_write0;
    logic [31:0] req_addr2, req_wdata2, req_addr0, req_wdata0;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata2, rsp_rdata0;
    logic [1:0]  dbg_state2, dbg_state0;

    logic [32:0] exp_q2[$];
    logic [32:0] exp_q0[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_rsp2 = 0, n_push2 = 0;

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required: finish earlier");
        $fatal(1, "watchdog");
    end

    mips_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_ready(req_ready2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .dbg_state(dbg_state2)
    );

    mips_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .dbg_state(dbg_state0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a response strobe is seen.
    always @(negedge clk) begin
        if (rsp_valid2) begin
            n_rsp2++;
            if (exp_q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp2_unexpected: got rsp_valid=1, required no response");
            end else begin
                check("rsp2_data", 64'({rsp_err2, rsp_rdata2}), 64'(exp_q2.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid0) begin
            if (exp_q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp0_unexpected: got rsp_valid=1, required no response");
            end else begin
                check("rsp0_data", 64'({rsp_err0, rsp_rdata0}), 64'(exp_q0.pop_front()));
            end
        end
    end

    // Driver: wait for ready, present for one accepting edge, record expectation.
    task automatic issue(input bit sel0, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [32:0] exp, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel0 ? req_ready0 : req_ready2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 for 50 cycles, required 1");
        end
        if (sel0) begin
            req_valid0 = 1'b1; req_write0 = wr; req_addr0 = a; req_wdata0 = d;
            if (push) exp_q0.push_back(exp);
        end else begin
            req_valid2 = 1'b1; req_write2 = wr; req_addr2 = a; req_wdata2 = d;
            if (push) begin
                exp_q2.push_back(exp);
                n_push2++;
            end
        end
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid2 = 1'b0;
    endtask

    task automatic drain(input bit sel0);
        int n;
        n = 0;
        while ((sel0 ? exp_q0.size() : exp_q2.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0",
                     sel0 ? exp_q0.size() : exp_q2.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst2 = 1'b0; rst0 = 1'b0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(req_ready2), 64'd0);
        check("reset_valid", 64'(rsp_valid2), 64'd0);
        check("reset_rdata", 64'(rsp_rdata2), 64'd0);
        check("reset_err",   64'(rsp_err2),   64'd0);
        check("reset_state", 64'(dbg_state2), 64'd0);
        rst2 = 1'b1; rst0 = 1'b1;

        // Store timing: response only in cycle 3, ready low in cycles 1..3.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, {1'b0, 32'hDEADBEEF}, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t1_ready", 64'(req_ready2), 64'(c == 4));
            check("t1_valid", 64'(rsp_valid2), 64'(c == 3));
        end
        issue(1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
        drain(1'b0);

        // Faults: misaligned store, out-of-range load, last valid word.
        issue(1'b0, 1'b1, 32'h13, 32'h11111111, {1'b1, 32'h0}, 1'b1);
        issue(1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
        issue(1'b0, 1'b0, 32'h400, 32'h0, {1'b1, 32'h0}, 1'b1);
        issue(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, {1'b0, 32'hCAFEF00D}, 1'b1);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1);
        issue(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, {1'b1, 32'h0}, 1'b1);
        drain(1'b0);

        // Reset during M_Wait aborts the store.
        issue(1'b0, 1'b1, 32'h20, 32'h1, {1'b0, 32'h1}, 1'b1);
        drain(1'b0);
        issue(1'b0, 1'b1, 32'h20, 32'h55, 33'h0, 1'b0);
        rst2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", 64'(req_ready2), 64'd0);
            check("rst_valid", 64'(rsp_valid2), 64'd0);
            check("rst_rdata", 64'(rsp_rdata2), 64'd0);
            check("rst_err",   64'(rsp_err2),   64'd0);
        end
        rst2 = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 1'b0, 32'h20, 32'h0, {1'b0, 32'h1}, 1'b1);
        drain(1'b0);

        // A request pulse during M_Wait is ignored.
        issue(1'b0, 1'b1, 32'h40, 32'h12345678, {1'b0, 32'h12345678}, 1'b1);
        drain(1'b0);
        issue(1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
        req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 32'h40; req_wdata2 = 32'hFFFF0000;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        drain(1'b0);
        repeat (4) @(negedge clk);
        issue(1'b0, 1'b0, 32'h40, 32'h0, {1'b0, 32'h12345678}, 1'b1);
        drain(1'b0);
        check("rsp2_count", 64'(n_rsp2), 64'(n_push2));

        // Zero wait states: back-to-back loads with req_valid held high.
        issue(1'b1, 1'b1, 32'h0, 32'hA, {1'b0, 32'hA}, 1'b1);
        issue(1'b1, 1'b1, 32'h4, 32'hB, {1'b0, 32'hB}, 1'b1);
        issue(1'b1, 1'b1, 32'h8, 32'hC, {1'b0, 32'hC}, 1'b1);
        drain(1'b1);
        exp_q0.push_back({1'b0, 32'hA});
        exp_q0.push_back({1'b0, 32'hB});
        exp_q0.push_back({1'b0, 32'hC});
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h0;
        for (int c = 0; c <= 6; c++) begin
            if (c >= 1) begin
                check("b2b_ready", 64'(req_ready0), 64'((c % 2) == 0));
                check("b2b_valid", 64'(rsp_valid0), 64'((c % 2) == 1 && c <= 5));
            end
            @(posedge clk);
            #1;
            if (c == 0) req_addr0 = 32'h4;
            if (c == 2) req_addr0 = 32'h8;
            if (c == 4) req_valid0 = 1'b0;
            @(negedge clk);
        end
        drain(1'b1);

        check("q2_empty", 64'(exp_q2.size()), 64'd0);
        check("q0_empty", 64'(exp_q0.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Word-addressed memory responder for the multicycle MIPS core. It sits on the memory side of the core's memory interface and serves the fetch, load (MemR) and store (DMW) accesses the controller issues. It accepts one request at a time, models a fixed number of wait states, and returns a single-cycle response with read data or an error flag. Instruction and data accesses share this one storage array.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two, minimum 2.
- `WAIT_CYCLES`, 2: extra busy cycles before the response; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = store, 0 = load/fetch.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  read data. Holds its value between responses.
- `rsp_err`  out  1  access faulted; qualified by `rsp_valid`.

## Operation
- States:
  - `M_Idle`: `req_ready`=1.
  - `M_Wait`: busy.
  - `M_Resp`: `rsp_valid`=1.
- Accept: on the edge where `req_valid && req_ready`, latch `req_write`, `req_addr` and `req_wdata`.
  - If `WAIT_CYCLES`=0, go to `M_Resp`.
  - Otherwise go to `M_Wait` with counter = `WAIT_CYCLES`-1.
- `M_Wait`: counter decrements each edge. At counter==0, the next edge goes to `M_Resp`.
- Fault check on the latched address. The access faults if either:
  - `addr[1:0]` != 0 (misaligned), or
  - `addr` >= `DEPTH_WORDS`*4 (out of range).
- Commit, on the edge entering `M_Resp`:
  - Fault: no array write; `rsp_rdata`<=0; `rsp_err`<=1.
  - Store: write the word at index `addr[log2(DEPTH_WORDS)+1:2]`; `rsp_rdata`<=`req_wdata`, echoed; `rsp_err`<=0.
  - Load: `rsp_rdata`<=array word; `rsp_err`<=0.
- `M_Resp`: always returns to `M_Idle` on the next edge. There is no response backpressure.
- `req_valid` outside `M_Idle` is ignored. No queueing, no error.
- Reset values, while `rst` is low:
  - State `M_Idle`, counter 0.
  - `req_ready`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Array contents are not reset.
- Reset mid-transaction aborts it. No array write happens, and no `rsp_valid` is produced.

## Timing
- Request presented in cycle 0 and accepted at the end of cycle 0. `rsp_valid` is high in cycle `WAIT_CYCLES`+1, for exactly one cycle.
- `req_ready` is low in cycles 1..`WAIT_CYCLES`+1. It is high again in cycle `WAIT_CYCLES`+2.
- The earliest next acceptance is cycle `WAIT_CYCLES`+2. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- A store is visible to any later request.
- `req_ready` and `rsp_valid` are decoded from the state register only. There is no combinational path from `req_*`.

## Structure
- Shared package contents:
  - `mem_state_t` enum (`M_Idle`, `M_Wait`, `M_Resp`).
  - `MEM_WORD_BYTES`=4.
  - Fault-code constant, for future extension.
- Sub-module `mips_mem_array`: synchronous-write, read-at-commit word array. Parameter `DEPTH_WORDS`; ports `clk`, `we`, `idx`, `wdata`, `rdata`.
- The responder top holds the FSM, wait counter, request latch and fault check.

## Test plan
- `WAIT_CYCLES`=2, store 0xDEADBEEF to 0x10 in cycle 0:
  - `rsp_valid` only in cycle 3, `rsp_err`=0.
  - `req_ready` low in cycles 1-3.
  - A following load of 0x10 returns 0xDEADBEEF.
- Store to misaligned 0x13:
  - `rsp_err`=1, `rsp_rdata`=0.
  - A load of 0x10 still returns 0xDEADBEEF.
- `DEPTH_WORDS`=256, load 0x400:
  - `rsp_err`=1, `rsp_rdata`=0.
  - Load 0x3FC returns `rsp_err`=0.
- 0x20 holds 0x1. Store 0x55 to 0x20, then drive `rst` low in cycle 1 (during `M_Wait`) and release:
  - No `rsp_valid`.
  - Outputs are zero during reset.
  - A load of 0x20 returns 0x1.
- `WAIT_CYCLES`=0, back-to-back loads with `req_valid` held high:
  - `rsp_valid` in cycles 1, 3, 5.
  - `req_ready` low only in cycles 1, 3, 5.
- During `M_Wait`, pulse `req_valid` with `req_addr`=0x40 and `req_write`=1:
  - Ignored; exactly one response, for the original request.
  - 0x40 is unchanged.
